// File: rtl/common_types_pkg.sv
// Shared type definitions for the execute stage.
// Holds the state encoding of the iterative multiply controller.
package common_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Iterative shift-add multiply controller for the execute stage.
// Consumes BITS_PER_CYCLE multiplier bits per cycle, exits early, and stalls the pipeline meanwhile.
module mult_ctrl
    import common_types_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_a,
    input  logic        signed_b,
    input  logic        half,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam int K = BITS_PER_CYCLE;
    localparam int N = 32 / BITS_PER_CYCLE;

    mult_state_t state, next_state;

    logic [63:0] mcand;
    logic [63:0] acc;
    logic [63:0] partial;
    logic [63:0] product;
    logic [31:0] mplier;
    logic [31:0] mplier_shifted;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [5:0]  count;
    logic        neg;
    logic        half_q;
    logic        neg_a;
    logic        neg_b;
    logic        neg_in;
    logic        accept;
    logic        calc_last;

    // Sign-magnitude split: the loop works on magnitudes, the sign is reapplied in FIX.
    always_comb begin
        neg_a  = signed_a & a[31];
        neg_b  = signed_b & b[31];
        mag_a  = neg_a ? (~a + 32'd1) : a;
        mag_b  = neg_b ? (~b + 32'd1) : b;
        neg_in = neg_a ^ neg_b;
    end

    always_comb begin
        partial = '0;
        for (int i = 0; i < K; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    assign accept         = (state == IDLE) && start && !flush;
    assign mplier_shifted = mplier >> K;
    assign calc_last      = (mplier_shifted == '0) || (count == 6'(N - 1));
    assign product        = neg ? (~acc + 64'd1) : acc;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (calc_last) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                stall      = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Datapath is frozen under flush so an aborted operation never touches result.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            half_q <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        neg    <= neg_in;
                        half_q <= half;
                        count  <= '0;
                        acc    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << K;
                    mplier <= mplier_shifted;
                    count  <= count + 6'd1;
                end
                FIX: begin
                    result <= half_q ? product[63:32] : product[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed multiplies with literal expectations,
// plus a cycle-level reference model compared against the outputs every cycle.
module tb_mult_ctrl;

    localparam int K = 2;
    localparam int N = 32 / K;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_a;
    logic        signed_b;
    logic        half;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors;
    int miscompares;
    logic check_en;

    // Reference model: cycles left until DONE, a DONE flag and the result register.
    int          left;
    logic        in_done;
    logic [31:0] exp_result;
    logic [31:0] pend_result;
    logic        exp_stall;

    mult_ctrl #(.BITS_PER_CYCLE(K)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .signed_a (signed_a),
        .signed_b (signed_b),
        .half     (half),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelResult(input logic [31:0] ia, input logic [31:0] ib,
                                                input logic isa, input logic isb, input logic ih);
        logic signed [64:0] ea;
        logic signed [64:0] eb;
        logic signed [64:0] p;
        ea = isa ? $signed({{33{ia[31]}}, ia}) : $signed({33'd0, ia});
        eb = isb ? $signed({{33{ib[31]}}, ib}) : $signed({33'd0, ib});
        p  = ea * eb;
        return ih ? p[63:32] : p[31:0];
    endfunction

    function automatic int calcCycles(input logic [31:0] ib, input logic isb);
        logic [31:0] m;
        int msb;
        int c;
        m   = (isb && ib[31]) ? (32'd0 - ib) : ib;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) msb = i;
        end
        if (msb < 0) return 1;
        c = (msb + 1 + K - 1) / K;
        return (c > N) ? N : c;
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            left       = 0;
            in_done    = 1'b0;
            exp_result = '0;
        end else if (flush) begin
            left    = 0;
            in_done = 1'b0;
        end else if (in_done) begin
            in_done = 1'b0;
        end else if (left > 1) begin
            left = left - 1;
        end else if (left == 1) begin
            left       = 0;
            in_done    = 1'b1;
            exp_result = pend_result;
        end else if (start) begin
            left        = calcCycles(b, signed_b) + 1;
            pend_result = modelResult(a, b, signed_a, signed_b, half);
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            exp_stall = ((left == 0) && !in_done && start && !flush) || (left > 0);
            checkOutput("cycle stall", 32'(stall), 32'(exp_stall));
            checkOutput("cycle done", 32'(done), 32'(in_done));
            checkOutput("cycle result", result, exp_result);
        end
    end

    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic isa, input logic isb, input logic ih);
        a        = ia;
        b        = ib;
        signed_a = isa;
        signed_b = isb;
        half     = ih;
        start    = 1'b1;
        flush    = 1'b0;
    endtask

    task automatic waitDone(input string name, input int exp_lat, input logic [31:0] exp_res);
        int n;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!done && n < 64);
        checkOutput({name, " latency"}, 32'(n), 32'(exp_lat));
        checkOutput({name, " result"}, result, exp_res);
        checkOutput({name, " stall in done"}, 32'(stall), 32'd0);
    endtask

    task automatic runOp(input string name, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isa, input logic isb, input logic ih,
                         input int exp_lat, input logic [31:0] exp_res);
        applyStimulus(ia, ib, isa, isb, ih);
        waitDone(name, exp_lat, exp_res);
        start = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        nRST        = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        a           = '0;
        b           = '0;
        signed_a    = 1'b0;
        signed_b    = 1'b0;
        half        = 1'b0;

        @(posedge CLK); #1;
        check_en = 1'b1;
        @(posedge CLK); #1;
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", result, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        runOp("mul 7x6", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 4, 32'd42);
        runOp("mul -3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 1'b0, 4, 32'hFFFFFFF1);
        runOp("mul 6x-7", 32'd6, 32'hFFFFFFF9, 1'b1, 1'b1, 1'b0, 4, 32'hFFFFFFD6);
        runOp("mulh min*min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 18, 32'h40000000);
        runOp("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 18, 32'hFFFFFFFF);
        runOp("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 18, 32'hFFFFFFFE);

        // Flush in CALC: abort, result keeps the previous value, then a fresh op runs.
        applyStimulus(32'd3, 32'h00010000, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (done) seen++;
        end
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        checkOutput("flush no done", 32'(seen + int'(done)), 32'd0);
        checkOutput("flush keeps result", result, 32'hFFFFFFFE);
        runOp("mul after flush", 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 3, 32'd6);

        // Flush has priority over start while idle.
        applyStimulus(32'd4, 32'd4, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("idle flush stall", 32'(stall), 32'd0);
        @(posedge CLK); #1;
        checkOutput("idle flush not accepted", 32'(stall), 32'd0);
        start = 1'b0;
        flush = 1'b0;
        @(posedge CLK); #1;

        // Reset in the middle of CALC clears result and suppresses done.
        applyStimulus(32'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge CLK); #1;
        end
        nRST  = 1'b0;
        start = 1'b0;
        @(posedge CLK); #1;
        checkOutput("midreset stall", 32'(stall), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset result", result, 32'd0);
        nRST = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (done) seen++;
        end
        checkOutput("midreset no done", 32'(seen), 32'd0);

        runOp("mul 7x6 again", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 4, 32'd42);

        // Back-to-back with start held high and b=0: DONE must not restart.
        applyStimulus(32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
        waitDone("b2b first", 3, 32'd0);
        @(posedge CLK); #1;
        checkOutput("b2b second accepted stall", 32'(stall), 32'd1);
        waitDone("b2b second", 3, 32'd0);
        start = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
